// File: rtl/cavlc_block_sequencer.sv
// cavlc_block_sequencer
//   Stage sequencer for the CAVLC residual decoder. For every 4x4 block of a
//   macroblock it runs coeff_token, level, total_zeros and run_before in
//   order, skipping stages with no work, forwards the active stage's shift
//   request to the shared bitstream shifter and aborts a stalled stage via a
//   watchdog.
//
// Ports
//   Clk, Reset             clock, synchronous active-high reset
//   Start, NumBlocks       macroblock start and block count (0..16)
//   Busy, MbDone, Error    status: non-idle, completion pulse, watchdog pulse
//   BlockIdx               0-based index of the block being decoded
//   *En / *Done            per-stage enable (out) and completion (in)
//   *NumShift / *ShiftEn   per-stage shift requests (in)
//   TotalCoeffIn/TrailingOnesIn  coeff_token results, valid with TokenDone
//   TotalCoeff/TrailingOnes      latched copies for the downstream stages
//   NumShift, ShiftEn      shift request forwarded to the bitstream shifter
module cavlc_block_sequencer #(
    parameter int unsigned MAX_COEFF = 16,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic [4:0] NumBlocks,
    output logic       Busy,
    output logic       MbDone,
    output logic       Error,
    output logic [3:0] BlockIdx,
    output logic       TokenEn,
    output logic       LevelEn,
    output logic       ZerosEn,
    output logic       RunEn,
    input  logic       TokenDone,
    input  logic       LevelDone,
    input  logic       ZerosDone,
    input  logic       RunDone,
    input  logic [4:0] TokenNumShift,
    input  logic [4:0] LevelNumShift,
    input  logic [4:0] ZerosNumShift,
    input  logic [4:0] RunNumShift,
    input  logic       TokenShiftEn,
    input  logic       LevelShiftEn,
    input  logic       ZerosShiftEn,
    input  logic       RunShiftEn,
    input  logic [4:0] TotalCoeffIn,
    input  logic [1:0] TrailingOnesIn,
    output logic [4:0] TotalCoeff,
    output logic [1:0] TrailingOnes,
    output logic [4:0] NumShift,
    output logic       ShiftEn
);

    typedef enum logic [2:0] {
        IDLE,
        TOKEN,
        LEVEL,
        ZEROS,
        RUN,
        NEXT
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [4:0] num_blocks;
    logic [6:0] wd_cnt;
    logic       zero_mb_done;
    logic       last_block;
    logic       stage_active;
    logic       wd_expired;
    logic       accept_start;

    assign stage_active = (state == TOKEN) || (state == LEVEL) ||
                          (state == ZEROS) || (state == RUN);
    assign wd_expired   = stage_active && (wd_cnt == 7'(TIMEOUT - 1));
    assign last_block   = ({1'b0, BlockIdx} == (num_blocks - 5'd1));
    assign accept_start = (state == IDLE) && Start && (NumBlocks != '0);

    assign Busy    = (state != IDLE);
    assign TokenEn = (state == TOKEN);
    assign LevelEn = (state == LEVEL);
    assign ZerosEn = (state == ZEROS);
    assign RunEn   = (state == RUN);
    // Final-block completion is decoded from NEXT; an empty macroblock uses a
    // registered pulse so it appears the cycle after Start.
    assign MbDone  = ((state == NEXT) && last_block) || zero_mb_done;

    // Next-state logic; a stage's Done wins over the watchdog in the same cycle.
    always_comb begin
        state_nxt = state;
        Error     = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept_start) state_nxt = TOKEN;
            end
            TOKEN: begin
                if (TokenDone) begin
                    state_nxt = (TotalCoeffIn == '0) ? NEXT : LEVEL;
                end else if (wd_expired) begin
                    state_nxt = IDLE;
                    Error     = 1'b1;
                end
            end
            LEVEL: begin
                if (LevelDone) begin
                    state_nxt = (TotalCoeff == 5'(MAX_COEFF)) ? NEXT : ZEROS;
                end else if (wd_expired) begin
                    state_nxt = IDLE;
                    Error     = 1'b1;
                end
            end
            ZEROS: begin
                if (ZerosDone) begin
                    state_nxt = RUN;
                end else if (wd_expired) begin
                    state_nxt = IDLE;
                    Error     = 1'b1;
                end
            end
            RUN: begin
                if (RunDone) begin
                    state_nxt = NEXT;
                end else if (wd_expired) begin
                    state_nxt = IDLE;
                    Error     = 1'b1;
                end
            end
            NEXT: begin
                state_nxt = last_block ? IDLE : TOKEN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shift request mux: only the active stage reaches the shifter.
    always_comb begin
        NumShift = '0;
        ShiftEn  = 1'b0;
        unique case (state)
            TOKEN: begin
                NumShift = TokenNumShift;
                ShiftEn  = TokenShiftEn;
            end
            LEVEL: begin
                NumShift = LevelNumShift;
                ShiftEn  = LevelShiftEn;
            end
            ZEROS: begin
                NumShift = ZerosNumShift;
                ShiftEn  = ZerosShiftEn;
            end
            RUN: begin
                NumShift = RunNumShift;
                ShiftEn  = RunShiftEn;
            end
            default: begin
                NumShift = '0;
                ShiftEn  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= IDLE;
            num_blocks   <= '0;
            BlockIdx     <= '0;
            TotalCoeff   <= '0;
            TrailingOnes <= '0;
            wd_cnt       <= '0;
            zero_mb_done <= 1'b0;
        end else begin
            state        <= state_nxt;
            zero_mb_done <= (state == IDLE) && Start && (NumBlocks == '0);
            // Counter runs only while a stage is waiting and restarts on any
            // state change, so each stage gets a full TIMEOUT window.
            if ((state_nxt != state) || !stage_active) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + 7'd1;
            end
            if (accept_start) begin
                num_blocks <= NumBlocks;
                BlockIdx   <= '0;
            end
            if ((state == TOKEN) && TokenDone) begin
                TotalCoeff   <= TotalCoeffIn;
                TrailingOnes <= TrailingOnesIn;
            end
            if ((state == NEXT) && !last_block) begin
                BlockIdx <= BlockIdx + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_cavlc_block_sequencer.sv
// tb_cavlc_block_sequencer
//   Self-checking bench for cavlc_block_sequencer. A stimulus process plays
//   macroblock plans (per-block TotalCoeff/TrailingOnes and per-stage Done
//   latency) cycle by cycle, drives random noise on every inactive stage, and
//   queues the outputs expected for that cycle. A monitor pops and compares.
module tb_cavlc_block_sequencer;

    localparam int MAXC = 16;
    localparam int TMO  = 64;

    localparam int S_IDLE  = 0;
    localparam int S_TOKEN = 1;
    localparam int S_LEVEL = 2;
    localparam int S_ZEROS = 3;
    localparam int S_RUN   = 4;
    localparam int S_NEXT  = 5;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic [4:0] NumBlocks = '0;
    logic       Busy, MbDone, Error;
    logic [3:0] BlockIdx;
    logic       TokenEn, LevelEn, ZerosEn, RunEn;
    logic       TokenDone = 1'b0, LevelDone = 1'b0, ZerosDone = 1'b0, RunDone = 1'b0;
    logic [4:0] TokenNumShift = '0, LevelNumShift = '0, ZerosNumShift = '0, RunNumShift = '0;
    logic       TokenShiftEn = 1'b0, LevelShiftEn = 1'b0, ZerosShiftEn = 1'b0, RunShiftEn = 1'b0;
    logic [4:0] TotalCoeffIn = '0;
    logic [1:0] TrailingOnesIn = '0;
    logic [4:0] TotalCoeff;
    logic [1:0] TrailingOnes;
    logic [4:0] NumShift;
    logic       ShiftEn;

    cavlc_block_sequencer #(.MAX_COEFF(16), .TIMEOUT(64)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .NumBlocks(NumBlocks),
        .Busy(Busy), .MbDone(MbDone), .Error(Error), .BlockIdx(BlockIdx),
        .TokenEn(TokenEn), .LevelEn(LevelEn), .ZerosEn(ZerosEn), .RunEn(RunEn),
        .TokenDone(TokenDone), .LevelDone(LevelDone), .ZerosDone(ZerosDone), .RunDone(RunDone),
        .TokenNumShift(TokenNumShift), .LevelNumShift(LevelNumShift),
        .ZerosNumShift(ZerosNumShift), .RunNumShift(RunNumShift),
        .TokenShiftEn(TokenShiftEn), .LevelShiftEn(LevelShiftEn),
        .ZerosShiftEn(ZerosShiftEn), .RunShiftEn(RunShiftEn),
        .TotalCoeffIn(TotalCoeffIn), .TrailingOnesIn(TrailingOnesIn),
        .TotalCoeff(TotalCoeff), .TrailingOnes(TrailingOnes),
        .NumShift(NumShift), .ShiftEn(ShiftEn)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [3:0] en;     // {token, level, zeros, run}
        logic       busy;
        logic       mbdone;
        logic       error;
        logic [3:0] idx;
        logic [4:0] tc;
        logic [1:0] t1;
        logic [4:0] ns;
        logic       se;
    } exp_t;

    exp_t expq[$];

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference state: latched coefficient info and current block index.
    logic [4:0] m_tc  = '0;
    logic [1:0] m_t1  = '0;
    int         m_idx = 0;
    bit         rst_req = 1'b1;

    // Macroblock plan; latency 0 means the stage never completes.
    int pl_tc  [16];
    int pl_t1  [16];
    int pl_lat [16][4];
    int rst_blk = -1;
    int rst_stg = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    // One clock cycle of stimulus plus the outputs expected during it.
    task automatic drive_cycle(input int st, input bit done, input bit mbd,
                               input bit err, input bit start, input int nbv,
                               input int tcv, input int t1v);
        exp_t e;
        @(posedge Clk);
        #1;
        Reset          = rst_req;
        TokenDone      = 1'($urandom_range(0, 1));
        LevelDone      = 1'($urandom_range(0, 1));
        ZerosDone      = 1'($urandom_range(0, 1));
        RunDone        = 1'($urandom_range(0, 1));
        TokenNumShift  = 5'($urandom);
        LevelNumShift  = 5'($urandom);
        ZerosNumShift  = 5'($urandom);
        RunNumShift    = 5'($urandom);
        TokenShiftEn   = 1'($urandom_range(0, 1));
        LevelShiftEn   = 1'($urandom_range(0, 1));
        ZerosShiftEn   = 1'($urandom_range(0, 1));
        RunShiftEn     = 1'($urandom_range(0, 1));
        TotalCoeffIn   = 5'($urandom);
        TrailingOnesIn = 2'($urandom);
        if (st == S_IDLE) Start = start;
        else              Start = 1'($urandom_range(0, 1));
        NumBlocks = start ? 5'(nbv) : 5'($urandom);

        e.ns = '0;
        e.se = 1'b0;
        case (st)
            S_TOKEN: begin
                TokenDone = done;
                if (done) begin
                    TotalCoeffIn   = 5'(tcv);
                    TrailingOnesIn = 2'(t1v);
                end
                e.ns = TokenNumShift; e.se = TokenShiftEn;
            end
            S_LEVEL: begin LevelDone = done; e.ns = LevelNumShift; e.se = LevelShiftEn; end
            S_ZEROS: begin ZerosDone = done; e.ns = ZerosNumShift; e.se = ZerosShiftEn; end
            S_RUN:   begin RunDone   = done; e.ns = RunNumShift;   e.se = RunShiftEn;   end
            default: ;
        endcase
        e.en     = {st == S_TOKEN, st == S_LEVEL, st == S_ZEROS, st == S_RUN};
        e.busy   = (st != S_IDLE);
        e.mbdone = mbd;
        e.error  = err;
        e.idx    = 4'(m_idx);
        e.tc     = m_tc;
        e.t1     = m_t1;
        expq.push_back(e);

        if (rst_req) begin
            m_tc  = '0;
            m_t1  = '0;
            m_idx = 0;
        end else if (st == S_TOKEN && done) begin
            m_tc = 5'(tcv);
            m_t1 = 2'(t1v);
        end
    endtask

    task automatic idle_cycle();
        drive_cycle(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    // Plays one macroblock from the current plan and ends back in IDLE.
    task automatic run_mb(input int nb);
        bit aborted;
        int lat;
        aborted = 1'b0;
        drive_cycle(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b1, nb, 0, 0);
        if (nb == 0) begin
            drive_cycle(S_IDLE, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0);
            idle_cycle();
            return;
        end
        for (int b = 0; b < nb && !aborted; b++) begin
            m_idx = b;
            for (int s = S_TOKEN; s <= S_RUN && !aborted; s++) begin
                if (s == S_LEVEL && pl_tc[b] == 0) break;
                if (s == S_ZEROS && pl_tc[b] == MAXC) break;
                lat = pl_lat[b][s-1];
                if (b == rst_blk && s == rst_stg) begin
                    rst_req = 1'b1;
                    drive_cycle(s, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
                    rst_req = 1'b0;
                    aborted = 1'b1;
                    break;
                end
                for (int c = 1; c <= TMO; c++) begin
                    bit d, er;
                    d  = (lat == c);
                    er = (c == TMO) && !d;
                    drive_cycle(s, d, 1'b0, er, 1'b0, 0, pl_tc[b], pl_t1[b]);
                    if (d) break;
                    if (er) begin
                        aborted = 1'b1;
                        break;
                    end
                end
            end
            if (!aborted) drive_cycle(S_NEXT, 1'b0, b == nb - 1, 1'b0, 1'b0, 0, 0, 0);
        end
        idle_cycle();
        idle_cycle();
    endtask

    task automatic rand_plan();
        for (int b = 0; b < 16; b++) begin
            int r;
            r = $urandom_range(0, 9);
            pl_tc[b] = (r == 0) ? 0 : (r == 1) ? MAXC : $urandom_range(1, 15);
            pl_t1[b] = $urandom_range(0, 3);
            for (int s = 0; s < 4; s++) begin
                pl_lat[b][s] = $urandom_range(1, 6);
                if ($urandom_range(0, 79) == 0) pl_lat[b][s] = 0;
            end
        end
    endtask

    task automatic fixed_plan(input int tc, input int t1, input int lt, input int ls);
        for (int b = 0; b < 16; b++) begin
            pl_tc[b] = tc;
            pl_t1[b] = t1;
            pl_lat[b][0] = lt;
            for (int s = 1; s < 4; s++) pl_lat[b][s] = ls;
        end
    endtask

    // Monitor: one queued expectation per cycle, sampled mid-cycle.
    always @(negedge Clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            chk("enables", {28'd0, TokenEn, LevelEn, ZerosEn, RunEn}, {28'd0, e.en});
            chk("busy",         {31'd0, Busy},   {31'd0, e.busy});
            chk("mbdone",       {31'd0, MbDone}, {31'd0, e.mbdone});
            chk("error",        {31'd0, Error},  {31'd0, e.error});
            chk("block_idx",    {28'd0, BlockIdx},     {28'd0, e.idx});
            chk("total_coeff",  {27'd0, TotalCoeff},   {27'd0, e.tc});
            chk("trailing_ones",{30'd0, TrailingOnes}, {30'd0, e.t1});
            chk("num_shift",    {27'd0, NumShift},     {27'd0, e.ns});
            chk("shift_en",     {31'd0, ShiftEn},      {31'd0, e.se});
        end
    end

    initial begin
        // Reset state check, then release.
        rst_req = 1'b1;
        idle_cycle();
        idle_cycle();
        rst_req = 1'b0;
        idle_cycle();

        // One block, full stage chain.
        fixed_plan(3, 1, 2, 3);
        run_mb(1);

        // Four empty blocks: TOKEN + NEXT each.
        fixed_plan(0, 0, 1, 1);
        run_mb(4);

        // Full block skips ZEROS and RUN.
        fixed_plan(MAXC, 3, 1, 2);
        run_mb(2);

        // LEVEL stalls until the watchdog fires, then a normal macroblock.
        fixed_plan(5, 2, 1, 2);
        pl_lat[0][1] = 0;
        run_mb(3);
        fixed_plan(7, 1, 1, 1);
        run_mb(2);

        // Done on the last allowed cycle beats the watchdog.
        fixed_plan(4, 0, 1, 1);
        pl_lat[0][2] = TMO;
        run_mb(1);

        // Reset in ZEROS of block 2, then an empty macroblock.
        fixed_plan(5, 2, 2, 2);
        rst_blk = 2;
        rst_stg = S_ZEROS;
        run_mb(4);
        rst_blk = -1;
        rst_stg = -1;
        run_mb(0);

        // Sixteen-block macroblock and random traffic.
        fixed_plan(1, 1, 1, 1);
        run_mb(16);
        for (int i = 0; i < 30; i++) begin
            rand_plan();
            run_mb($urandom_range(0, 16));
        end

        repeat (3) @(posedge Clk);
        chk("queue_drained", expq.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cavlc_block_sequencer.md
# cavlc_block_sequencer

Stage sequencer for the CAVLC residual decoder. For each 4x4 block of a macroblock it runs four sub-decoders in order: coeff_token, level decode, total_zeros and run_before. It drives each stage's Enable, watches each stage's Done, and forwards the active stage's shift request to the shared bitstream shifter. It also latches TotalCoeff/TrailingOnes for the downstream stages, skips stages that have no work, and flags stalled stages with a watchdog.

## Interface
Parameters:
- MAX_COEFF, 16, coefficients per block; TotalCoeff == MAX_COEFF skips the ZEROS and RUN stages.
- TIMEOUT, 64, maximum cycles in one stage before Error is raised.

Ports:
- Clk  in  1  clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  starts a macroblock; sampled only in IDLE.
- NumBlocks  in  5  blocks to decode, 0..16; captured on an accepted Start.
- Busy  out  1  high in any state other than IDLE.
- MbDone  out  1  one-cycle pulse when the macroblock completes.
- Error  out  1  one-cycle pulse on watchdog expiry.
- BlockIdx  out  4  index of the current block, 0-based.
- TokenEn, LevelEn, ZerosEn, RunEn  out  1 each  stage enables.
- TokenDone, LevelDone, ZerosDone, RunDone  in  1 each  stage completion; may be combinational.
- TokenNumShift, LevelNumShift, ZerosNumShift, RunNumShift  in  5 each  stage shift amounts.
- TokenShiftEn, LevelShiftEn, ZerosShiftEn, RunShiftEn  in  1 each  stage shift requests.
- TotalCoeffIn  in  5  coeff_token result; valid in the cycle TokenDone is high.
- TrailingOnesIn  in  2  coeff_token result; valid in the cycle TokenDone is high.
- TotalCoeff  out  5  registered copy of TotalCoeffIn for downstream stages.
- TrailingOnes  out  2  registered copy of TrailingOnesIn for downstream stages.
- NumShift  out  5  shift amount forwarded to the bitstream shifter.
- ShiftEn  out  1  shift request forwarded to the bitstream shifter.

## Operation
- States: IDLE, TOKEN, LEVEL, ZEROS, RUN, NEXT.
- Enables are Moore outputs decoded from state: TokenEn=(TOKEN), LevelEn=(LEVEL), ZerosEn=(ZEROS), RunEn=(RUN).
- IDLE:
  - Start with NumBlocks>0: capture NumBlocks, BlockIdx<=0, go to TOKEN.
  - Start with NumBlocks==0: pulse MbDone next cycle, stay IDLE.
- TOKEN & TokenDone: latch TotalCoeff<=TotalCoeffIn and TrailingOnes<=TrailingOnesIn, then:
  - TotalCoeffIn==0 -> NEXT.
  - otherwise -> LEVEL.
- LEVEL & LevelDone:
  - TotalCoeff==MAX_COEFF -> NEXT.
  - otherwise -> ZEROS.
- ZEROS & ZerosDone -> RUN.
- RUN & RunDone -> NEXT.
- NEXT lasts exactly one cycle with all enables low, so every stage sees Enable fall before its next block:
  - if BlockIdx==NumBlocks-1: pulse MbDone, go to IDLE.
  - otherwise: BlockIdx<=BlockIdx+1, go to TOKEN.
- Shift forwarding is combinational from the active stage's inputs:
  - NumShift/ShiftEn are the active stage's NumShift/ShiftEn.
  - In IDLE and NEXT, NumShift=0 and ShiftEn=0.
  - Inputs from inactive stages are ignored.
- Watchdog:
  - 7-bit cycle counter, cleared on every state change.
  - If it reaches TIMEOUT-1 while still in TOKEN, LEVEL, ZEROS or RUN without Done: pulse Error, go to IDLE, no MbDone.
- Stage-decoding edge rules:
  - Done inputs are honoured only for the active stage.
  - Start is ignored while Busy.
  - Done from the active stage takes priority over watchdog expiry in the same cycle.

## Timing
- Reset: state=IDLE. Busy, MbDone, Error, BlockIdx, all enables, TotalCoeff, TrailingOnes, NumShift, ShiftEn and the watchdog counter are all 0.
- Reset mid-operation takes effect at the next edge; all enables drop that same edge.
- Start at edge t -> TokenEn high from t+1.
- Done high during cycle t -> current enable low and next stage's enable high from t+1. Zero bubble between stages.
- NEXT adds one bubble per block.
- Minimum block with TotalCoeff=0, TokenDone in its first cycle: TOKEN (1) + NEXT (1) = 2 cycles.
- MbDone is asserted during the final NEXT cycle; Busy falls the following cycle.
- TotalCoeff/TrailingOnes update one edge after TokenDone and hold until the next TokenDone or Reset.

## Test plan
- NumBlocks=1; TokenDone in 2nd TOKEN cycle with TotalCoeffIn=3, TrailingOnesIn=1; LevelDone, ZerosDone, RunDone each after 3 cycles -> enables fire strictly in order, TotalCoeff=3 and TrailingOnes=1 from the edge after TokenDone, MbDone pulses once, Busy low afterwards.
- NumBlocks=4, TotalCoeffIn=0 every block, TokenDone immediate -> LevelEn/ZerosEn/RunEn never high, BlockIdx steps 0,1,2,3, MbDone on cycle 8 after Start.
- TotalCoeffIn=16 (MAX_COEFF) -> LEVEL goes to NEXT, ZerosEn and RunEn never assert.
- In LEVEL, drive LevelNumShift=7 and LevelShiftEn=1 while TokenShiftEn=1 and TokenNumShift=3 -> NumShift=7, ShiftEn=1; in NEXT, NumShift=0 and ShiftEn=0.
- LevelDone held low for 64 cycles -> Error pulses on the 64th LEVEL cycle, state returns to IDLE, no MbDone; a later Start is accepted normally.
- Reset asserted during ZEROS of block 2 -> all outputs 0 next edge; Start issued while Busy is ignored, and NumBlocks=0 with Start gives an MbDone pulse and no enables.
